// File: rtl/temp_sample_sched.sv
// temp_sample_sched: periodic / triggered sampling scheduler for the SPI
// temperature sensor. Generates the sample period, arbitrates manual
// triggers, runs the start/busy/done handshake with the SPI master, and
// holds the last sensor word plus sticky overrun/timeout status.
//
// state       | meaning
// ------------+----------------------------------------------------------
// S_IDLE      | no transaction; waiting for a pending request
// S_WAIT_IDLE | request pending but the SPI master is still busy
// S_START     | one-cycle start pulse to the SPI master, pending cleared
// S_WAIT_DONE | waiting for spi_done_in, guarded by the timeout counter
module temp_sample_sched #(
  parameter int CLK_PER_MS     = 180000,
  parameter int PERIOD_MS      = 1000,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int DATA_W         = 16
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              enable_in,
  input  logic              trig_in,
  input  logic              clr_err_in,
  input  logic              spi_busy_in,
  input  logic              spi_done_in,
  input  logic [DATA_W-1:0] spi_data_in,
  output logic              spi_start_out,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid_out,
  output logic              sample_ready_out,
  output logic [7:0]        sample_cnt_out,
  output logic              overrun_err_out,
  output logic              timeout_err_out
);

  localparam int P_CYC = CLK_PER_MS * PERIOD_MS;
  localparam int PW    = $clog2(P_CYC) + 1;
  localparam int TW    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [PW-1:0] P_LAST = PW'(P_CYC - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_IDLE = 2'd1,
    S_START     = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PW-1:0]     r_period_cnt;
  logic [TW-1:0]     r_tout_cnt;
  logic              r_pending;
  logic [DATA_W-1:0] r_sample;
  logic              r_valid;
  logic              r_ready;
  logic [7:0]        r_cnt;
  logic              r_overrun;
  logic              r_timeout;

  logic w_period_hit;
  logic w_req;
  logic w_overrun;
  logic w_done_ok;
  logic w_tout_hit;

  assign w_period_hit = enable_in && (r_period_cnt == P_LAST);
  // A period tick and a trigger in the same cycle collapse into one request.
  assign w_req        = enable_in && (w_period_hit || trig_in);
  // In START the pending flag is being consumed, so a new request is not lost.
  assign w_overrun    = w_req && r_pending && (r_state != S_START);
  assign w_done_ok    = (r_state == S_WAIT_DONE) && spi_done_in;
  // Done on the last allowed cycle takes priority over the timeout.
  assign w_tout_hit   = (r_state == S_WAIT_DONE) && !spi_done_in &&
                        (r_tout_cnt == T_LAST);

  // Free-running sample period counter, held at zero while disabled.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in || !enable_in) begin
      r_period_cnt <= '0;
    end else if (w_period_hit) begin
      r_period_cnt <= '0;
    end else begin
      r_period_cnt <= r_period_cnt + PW'(1);
    end
  end

  // Single-entry request latch; consumed by START, re-armable in the same cycle.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in || !enable_in) begin
      r_pending <= 1'b0;
    end else if (w_req) begin
      r_pending <= 1'b1;
    end else if (r_state == S_START) begin
      r_pending <= 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_pending) begin
          w_state_nxt = spi_busy_in ? S_WAIT_IDLE : S_START;
        end
      end
      S_WAIT_IDLE: begin
        if (!r_pending) begin
          w_state_nxt = S_IDLE;
        end else if (!spi_busy_in) begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (w_done_ok || w_tout_hit) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Timeout counter: cleared on start, counts cycles spent waiting for done.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_tout_cnt <= '0;
    end else if (r_state == S_START) begin
      r_tout_cnt <= '0;
    end else if ((r_state == S_WAIT_DONE) && !spi_done_in && !w_tout_hit) begin
      r_tout_cnt <= r_tout_cnt + TW'(1);
    end
  end

  // Sample capture, valid pulse, ready flag and wrapping sample counter.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_sample <= '0;
      r_valid  <= 1'b0;
      r_ready  <= 1'b0;
      r_cnt    <= 8'd0;
    end else begin
      r_valid <= w_done_ok;
      if (w_done_ok) begin
        r_sample <= spi_data_in;
        r_ready  <= 1'b1;
        r_cnt    <= r_cnt + 8'd1;
      end
    end
  end

  // Sticky error flags; a new error event beats a simultaneous clear.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (w_overrun) begin
        r_overrun <= 1'b1;
      end else if (clr_err_in) begin
        r_overrun <= 1'b0;
      end
      if (w_tout_hit) begin
        r_timeout <= 1'b1;
      end else if (clr_err_in) begin
        r_timeout <= 1'b0;
      end
    end
  end

  assign spi_start_out    = (r_state == S_START);
  assign sample_out       = r_sample;
  assign sample_valid_out = r_valid;
  assign sample_ready_out = r_ready;
  assign sample_cnt_out   = r_cnt;
  assign overrun_err_out  = r_overrun;
  assign timeout_err_out  = r_timeout;

endmodule

// File: tb/tb_temp_sample_sched.sv
// Testbench for temp_sample_sched: directed stimulus with a scoreboard.
// Stimulus pushes expected start cycles and samples into queues; a monitor
// pops and compares whenever the DUT pulses spi_start_out or sample_valid_out.
// A small SPI responder answers each start with a programmable busy/done shape.
module tb_temp_sample_sched;

  typedef struct {
    logic [15:0] data;
    int          delay;   // cycle offset of done after start; 0 = never
  } resp_t;

  typedef struct {
    logic [15:0] data;
    logic [7:0]  cnt;
  } samp_t;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        trig;
  logic        clr_err;
  logic        ext_busy;
  logic        resp_busy;
  logic        spi_busy;
  logic        spi_done;
  logic [15:0] spi_data;
  logic        spi_start_out;
  logic [15:0] sample_out;
  logic        sample_valid_out;
  logic        sample_ready_out;
  logic [7:0]  sample_cnt_out;
  logic        overrun_err_out;
  logic        timeout_err_out;

  int    cyc = 0;
  int    n_checks = 0;
  int    n_fail = 0;
  int    t0;
  int    t1;
  int    start_q[$];
  resp_t resp_q[$];
  samp_t sample_q[$];

  assign spi_busy = ext_busy | resp_busy;

  temp_sample_sched #(
    .CLK_PER_MS    (10),
    .PERIOD_MS     (2),
    .TIMEOUT_CYCLES(8),
    .DATA_W        (16)
  ) dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .enable_in       (enable),
    .trig_in         (trig),
    .clr_err_in      (clr_err),
    .spi_busy_in     (spi_busy),
    .spi_done_in     (spi_done),
    .spi_data_in     (spi_data),
    .spi_start_out   (spi_start_out),
    .sample_out      (sample_out),
    .sample_valid_out(sample_valid_out),
    .sample_ready_out(sample_ready_out),
    .sample_cnt_out  (sample_cnt_out),
    .overrun_err_out (overrun_err_out),
    .timeout_err_out (timeout_err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_start"},   {31'd0, spi_start_out},    32'd0);
    check({tag, "_sample"},  {16'd0, sample_out},       32'd0);
    check({tag, "_valid"},   {31'd0, sample_valid_out}, 32'd0);
    check({tag, "_ready"},   {31'd0, sample_ready_out}, 32'd0);
    check({tag, "_cnt"},     {24'd0, sample_cnt_out},   32'd0);
    check({tag, "_overrun"}, {31'd0, overrun_err_out},  32'd0);
    check({tag, "_timeout"}, {31'd0, timeout_err_out},  32'd0);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push_txn(input int start_cyc, input logic [15:0] data, input int delay,
                          input logic [7:0] cnt, input bit expect_sample);
    resp_t r;
    samp_t s;
    start_q.push_back(start_cyc);
    r.data  = data;
    r.delay = delay;
    resp_q.push_back(r);
    if (expect_sample) begin
      s.data = data;
      s.cnt  = cnt;
      sample_q.push_back(s);
    end
  endtask

  function automatic logic [15:0] wrap_word(input int k);
    int v;
    v = k * 257 + 'h1234;
    return v[15:0];
  endfunction

  // SPI responder: busy for a few cycles after each start, then an optional done.
  initial begin : responder
    resp_t r;
    int    last_busy;
    int    n_steps;
    resp_busy = 1'b0;
    spi_done  = 1'b0;
    spi_data  = 16'h0000;
    forever begin
      @(negedge clk);
      if (spi_start_out === 1'b1) begin
        if (resp_q.size() > 0) begin
          r = resp_q.pop_front();
        end else begin
          r.data  = 16'h0000;
          r.delay = 0;
        end
        last_busy = (r.delay == 0) ? 5 : r.delay - 1;
        n_steps   = (r.delay == 0) ? 6 : r.delay + 1;
        for (int k = 1; k <= n_steps; k++) begin
          @(negedge clk);
          resp_busy = (k <= last_busy);
          spi_done  = (k == r.delay);
          spi_data  = (k == r.delay) ? r.data : 16'h0000;
        end
      end
    end
  end

  // Monitor: every start and every valid pulse must match the next expectation.
  initial begin : monitor
    int    e;
    samp_t s;
    forever begin
      @(negedge clk);
      if (spi_start_out === 1'b1) begin
        if (start_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_start: spi_start_out=1 at cycle %0d, none expected", cyc);
        end else begin
          e = start_q.pop_front();
          check("start_cycle", cyc, e);
        end
      end
      if (sample_valid_out === 1'b1) begin
        if (sample_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_valid: sample_valid_out=1 at cycle %0d, none expected", cyc);
        end else begin
          s = sample_q.pop_front();
          check("sample_data",  {16'd0, sample_out},       {16'd0, s.data});
          check("sample_cnt",   {24'd0, sample_cnt_out},   {24'd0, s.cnt});
          check("sample_ready", {31'd0, sample_ready_out}, 32'd1);
        end
      end
    end
  end

  initial begin : stimulus
    rst_n    = 1'b0;
    enable   = 1'b0;
    trig     = 1'b0;
    clr_err  = 1'b0;
    ext_busy = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");

    // Periodic sampling: period 20 cycles, counter restarts from reset release.
    rst_n  = 1'b1;
    enable = 1'b1;
    t0     = cyc + 1;
    push_txn(t0 + 20, 16'h1A40, 6, 8'd1, 1'b1);
    push_txn(t0 + 40, 16'h1A40, 6, 8'd2, 1'b1);
    push_txn(t0 + 60, 16'h1A40, 6, 8'd3, 1'b1);

    // Manual trigger mid-period; the periodic start at +80 must stay on time.
    push_txn(t0 + 72, 16'h2B51, 6, 8'd4, 1'b1);
    push_txn(t0 + 80, 16'h2B51, 6, 8'd5, 1'b1);
    wait_until(t0 + 70);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;

    // Busy SPI master holds a pending request; a second request overruns.
    push_txn(t0 + 109, 16'h3C62, 6, 8'd6, 1'b1);
    wait_until(t0 + 90);
    ext_busy = 1'b1;
    wait_until(t0 + 102);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    wait_until(t0 + 104);
    check("overrun_set",        {31'd0, overrun_err_out}, 32'd1);
    check("no_timeout_overrun", {31'd0, timeout_err_out}, 32'd0);
    wait_until(t0 + 108);
    ext_busy = 1'b0;
    wait_until(t0 + 116);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    @(negedge clk);
    check("overrun_cleared", {31'd0, overrun_err_out}, 32'd0);

    // Done never arrives: timeout after 8 waiting cycles, sample state kept.
    push_txn(t0 + 120, 16'hDEAD, 0, 8'd0, 1'b0);
    wait_until(t0 + 128);
    check("timeout_not_early", {31'd0, timeout_err_out},  32'd0);
    @(negedge clk);
    check("timeout_set",       {31'd0, timeout_err_out},  32'd1);
    check("timeout_keep_data", {16'd0, sample_out},       32'h3C62);
    check("timeout_keep_cnt",  {24'd0, sample_cnt_out},   32'd6);
    check("timeout_ready",     {31'd0, sample_ready_out}, 32'd1);

    // Done lands on the expiry cycle: captured, no timeout.
    push_txn(t0 + 140, 16'h4D73, 8, 8'd7, 1'b1);
    wait_until(t0 + 130);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    @(negedge clk);
    check("timeout_cleared", {31'd0, timeout_err_out}, 32'd0);
    wait_until(t0 + 150);
    check("expiry_done_no_timeout", {31'd0, timeout_err_out}, 32'd0);
    check("expiry_done_data",       {16'd0, sample_out},      32'h4D73);

    // Reset in the middle of WAIT_DONE: everything clears, no later pulses.
    push_txn(t0 + 160, 16'h5E84, 6, 8'd0, 1'b0);
    wait_until(t0 + 162);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("mid_txn_reset");
    wait_until(t0 + 167);
    rst_n = 1'b1;
    t1    = cyc + 1;
    for (int k = 1; k <= 256; k++) begin
      push_txn(t1 + 20 * k, wrap_word(k), 6, 8'(k), 1'b1);
    end
    wait_until(t1 + 5);
    check_all_zero("post_reset");

    // 256 periodic samples: counter wraps to 0, ready stays set.
    wait_until(t1 + 20 * 256 + 10);
    check("wrap_cnt",   {24'd0, sample_cnt_out},   32'd0);
    check("wrap_ready", {31'd0, sample_ready_out}, 32'd1);
    check("wrap_data",  {16'd0, sample_out},       {16'd0, wrap_word(256)});

    // Disabled: no further starts.
    enable = 1'b0;
    wait_until(t1 + 20 * 256 + 60);
    check("starts_left",  start_q.size(),  32'd0);
    check("samples_left", sample_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/temp_sample_sched.md
Name: temp_sample_sched

Overview:
Periodic sampling scheduler for the SPI temperature sensor path. It generates the sample period internally, accepts manual trigger requests, and sequences the SPI master through a start/busy/done handshake. It captures each returned sensor word and holds it for downstream logic. It also flags overruns and stalled transactions. It sits between the SPI master and the display/reporting logic.

Parameters:
CLK_PER_MS, 180000, clk_in cycles per millisecond
PERIOD_MS, 1000, sample period in ms; period = CLK_PER_MS*PERIOD_MS cycles
TIMEOUT_CYCLES, 4096, max cycles to wait for spi_done_in after start
DATA_W, 16, sensor word width

Ports:
clk_in  input  1  system clock, all logic on rising edge
rst_n_in  input  1  synchronous reset, active low
enable_in  input  1  1 = periodic sampling and triggers allowed
trig_in  input  1  single-cycle manual sample request
clr_err_in  input  1  clears sticky overrun/timeout flags
spi_busy_in  input  1  SPI master transaction in progress
spi_done_in  input  1  single-cycle pulse, transaction finished, data valid
spi_data_in  input  DATA_W  received sensor word, valid with spi_done_in
spi_start_out  output  1  single-cycle start pulse to SPI master
sample_out  output  DATA_W  last captured sensor word
sample_valid_out  output  1  single-cycle pulse, sample_out updated
sample_ready_out  output  1  sticky, at least one sample captured since reset
sample_cnt_out  output  8  captured-sample counter, wraps 255->0
overrun_err_out  output  1  sticky, request lost because one was already pending
timeout_err_out  output  1  sticky, transaction timed out

Behaviour:
- Reset (rst_n_in=0 at an edge): all outputs 0, period counter 0, pending 0, timeout counter 0, state IDLE. Reset mid-transaction aborts immediately and emits no start or valid pulse afterwards.
- Period counter:
  - Width $clog2(CLK_PER_MS*PERIOD_MS)+1.
  - Counts 0..P-1 while enable_in=1, where P=CLK_PER_MS*PERIOD_MS.
  - At count P-1 it wraps to 0 and raises a period request.
  - enable_in=0 holds it at 0.
- Pending flag:
  - Set by a period request or trig_in (both gated by enable_in); visible the next cycle.
  - Cleared in START.
  - If a request arrives while pending=1, overrun_err_out<=1 and the request is dropped.
  - Period request and trig_in in the same cycle merge into one request; no overrun.
  - A request arriving in the same cycle pending clears is accepted and sets pending again.
  - enable_in=0 clears pending.
  - Requests during WAIT_DONE set pending normally; they are not overruns unless pending is already 1.
- FSM:
  - IDLE: if pending=1 and spi_busy_in=0, go to START. If pending=1 and spi_busy_in=1, go to WAIT_IDLE.
  - WAIT_IDLE: go to START when spi_busy_in=0. If pending is cleared (enable_in=0), go to IDLE.
  - START: spi_start_out=1 for exactly this one cycle, clear pending, clear timeout counter, go to WAIT_DONE.
  - WAIT_DONE, spi_done_in=1: sample_out<=spi_data_in, sample_valid_out<=1 for one cycle, sample_ready_out<=1, sample_cnt_out+=1 (mod 256), go to IDLE.
  - WAIT_DONE, no done: timeout counter increments. At TIMEOUT_CYCLES-1 without done, set timeout_err_out<=1, go to IDLE, leave sample_out/sample_cnt_out unchanged.
  - done and timeout expiry in the same cycle: done wins, no timeout flag.
- Latency: trig_in at edge N (idle, SPI not busy) gives spi_start_out high in the cycle after N+1. sample_valid_out rises at the edge after spi_done_in is sampled.
- spi_done_in outside WAIT_DONE is ignored.
- Enable dropping mid-transaction: the in-flight transaction still completes normally.
- clr_err_in=1 clears both sticky flags. If an error event occurs in the same cycle, the set wins.
- Minimum period between starts is START + WAIT_DONE + IDLE (≥3 cycles).

Test Plan:
- Reset then idle. CLK_PER_MS=10, PERIOD_MS=2, enable_in=1, SPI model busy 5 cycles with data 0x1A40 -> spi_start_out pulses every 20 cycles; sample_out=0x1A40; sample_valid_out 1-cycle pulses; sample_cnt_out 1,2,3.
- trig_in pulse with enable_in=1 mid-period, SPI idle -> exactly one spi_start_out 2 cycles later; period counter continues undisturbed.
- Hold spi_busy_in=1 while a request is pending, and inject a second request -> FSM waits in WAIT_IDLE with no start pulse; overrun_err_out=1; one start after busy drops; clr_err_in -> 0.
- SPI model never asserts done, TIMEOUT_CYCLES=8 -> timeout_err_out=1 exactly 8 cycles after start; sample_out and sample_cnt_out unchanged; next request still starts.
- Done arrives on the expiry cycle -> sample captured and timeout_err_out stays 0.
- rst_n_in=0 during WAIT_DONE -> all outputs 0 next cycle. 256 captured samples -> sample_cnt_out wraps to 0 while sample_ready_out stays 1.
